// File: rtl/myriscv_mc.sv
// Multi-cycle RV32I-subset core. Fetch and data accesses share one req/ack memory port.
// Illegal encodings, bad register indices and misaligned accesses park the core in HALT.
module myriscv_mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32,
  parameter int          RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ack,
  output logic                halted,
  output logic                trap,
  output logic [RETIRE_W-1:0] retired,
  output logic [31:0]         pc_dbg
);
  localparam int IDX_W = $clog2(NREGS);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [2:0] {C_ALU, C_ADDI, C_LW, C_SW, C_BR, C_ECALL, C_ILL} class_e;

  state_e              state_q, state_d;
  logic [31:0]         pc_q, pc_d, ir_q, ir_d;
  logic [31:0]         op_a_q, op_a_d, op_b_q, op_b_d, alu_q, alu_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic                halted_q, halted_d, trap_q, trap_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic [31:0]         rf_q [NREGS];
  logic                rf_we;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

  // Only 16 or 32 registers exist, so index bit 4 is the whole range test for RV32E.
  function automatic logic idx_bad(input logic [4:0] r);
    return (NREGS == 16) && r[4];
  endfunction

  class_e cls;
  logic   use_rs1, use_rs2, use_rd, illegal;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    cls     = C_ILL;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      7'b0110011: if ((funct7 == 7'b0000000 && funct3 inside {3'b000, 3'b111, 3'b110, 3'b010}) ||
                      (funct7 == 7'b0100000 && funct3 == 3'b000)) begin
        cls = C_ALU; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
      end
      7'b0010011: if (funct3 == 3'b000) begin
        cls = C_ADDI; use_rs1 = 1'b1; use_rd = 1'b1;
      end
      7'b0000011: if (funct3 == 3'b010) begin
        cls = C_LW; use_rs1 = 1'b1; use_rd = 1'b1;
      end
      7'b0100011: if (funct3 == 3'b010) begin
        cls = C_SW; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b1100011: if (funct3 == 3'b000 || funct3 == 3'b001) begin
        cls = C_BR; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b1110011: if (ir_q == 32'h0000_0073) cls = C_ECALL;
      default: ;
    endcase
    illegal = (cls == C_ILL) || (use_rs1 && idx_bad(rs1)) ||
              (use_rs2 && idx_bad(rs2)) || (use_rd && idx_bad(rd));
  end

  logic [31:0] alu_res, ls_addr, pc_plus4, br_next;
  logic        br_taken;

  always_comb begin
    alu_res = op_a_q + op_b_q;
    if (cls == C_ADDI) begin
      alu_res = op_a_q + imm_i;
    end else begin
      case (funct3)
        3'b000:  alu_res = funct7[5] ? op_a_q - op_b_q : op_a_q + op_b_q;
        3'b111:  alu_res = op_a_q & op_b_q;
        3'b110:  alu_res = op_a_q | op_b_q;
        3'b010:  alu_res = {31'b0, $signed(op_a_q) < $signed(op_b_q)};
        default: ;
      endcase
    end
  end

  assign ls_addr  = op_a_q + ((cls == C_SW) ? imm_s : imm_i);
  assign pc_plus4 = pc_q + 32'd4;
  assign br_taken = funct3[0] ? (op_a_q != op_b_q) : (op_a_q == op_b_q);
  assign br_next  = br_taken ? pc_q + imm_b : pc_plus4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    alu_d       = alu_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    halted_d    = halted_q;
    trap_d      = trap_q;
    retired_d   = retired_q;
    rf_we       = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Only the first fetch after reset arrives here without a request already raised.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end else if (mem_ack) begin
          ir_d      = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        op_a_d = rf_q[rs1[IDX_W-1:0]];
        op_b_d = rf_q[rs2[IDX_W-1:0]];
        if (illegal) begin
          state_d = S_HALT; halted_d = 1'b1; trap_d = 1'b1;
        end else if (cls == C_ECALL) begin
          state_d = S_HALT; halted_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_ALU, C_ADDI: begin
            alu_d   = alu_res;
            state_d = S_WB;
          end
          C_LW, C_SW: begin
            if (ls_addr[1:0] != 2'b00) begin
              state_d = S_HALT; halted_d = 1'b1; trap_d = 1'b1;
            end else begin
              mem_req_d   = 1'b1;
              mem_we_d    = (cls == C_SW);
              mem_addr_d  = ls_addr;
              mem_wdata_d = (cls == C_SW) ? op_b_q : 32'd0;
              state_d     = S_MEM;
            end
          end
          C_BR: begin
            // A taken branch to a non-word address would be a misaligned fetch.
            if (br_next[1]) begin
              state_d = S_HALT; halted_d = 1'b1; trap_d = 1'b1;
            end else begin
              pc_d       = br_next;
              retired_d  = retired_q + 1'b1;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = br_next;
              state_d    = S_FETCH;
            end
          end
          default: begin
            state_d = S_HALT; halted_d = 1'b1; trap_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (mem_we_q) begin
            pc_d       = pc_plus4;
            retired_d  = retired_q + 1'b1;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_plus4;
            state_d    = S_FETCH;
          end else begin
            alu_d     = mem_rdata;
            mem_req_d = 1'b0;
            state_d   = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        pc_d       = pc_plus4;
        retired_d  = retired_q + 1'b1;
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = pc_plus4;
        state_d    = S_FETCH;
      end
      S_HALT: ;
      default: begin
        state_d = S_HALT; halted_d = 1'b1; trap_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 32'd0;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      alu_q       <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= RESET_PC;
      mem_wdata_q <= 32'd0;
      halted_q    <= 1'b0;
      trap_q      <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      alu_q       <= alu_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
      trap_q      <= trap_d;
      retired_q   <= retired_d;
    end
  end

  // NOTE: the register file is reset because software may read any register before writing it;
  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= 32'd0;
    end else if (rf_we && rd != 5'd0) begin
      rf_q[rd[IDX_W-1:0]] <= alu_q;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign halted    = halted_q;
  assign trap      = trap_q;
  assign retired   = retired_q;
  assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_myriscv_mc.sv
// Directed bench for myriscv_mc: an RV32I core at 0x100 with a wait-state memory model,
// plus an RV32E core for the register-range trap.
module tb_myriscv_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_b;
  logic        mem_req, mem_we, halted, trap;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, retired, pc_dbg;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_req_b, mem_we_b, halted_b, trap_b;
  logic        mem_ack_b = 1'b0;
  logic [31:0] mem_addr_b, mem_wdata_b, retired_b, pc_dbg_b;
  logic [31:0] mem_rdata_b = 32'd0;

  myriscv_mc #(.RESET_PC(32'h100), .NREGS(32), .RETIRE_W(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halted(halted),
    .trap(trap), .retired(retired), .pc_dbg(pc_dbg));

  myriscv_mc #(.RESET_PC(32'h0), .NREGS(16), .RETIRE_W(32)) dut_e (
    .clk(clk), .rst(rst_b), .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .mem_ack(mem_ack_b), .halted(halted_b),
    .trap(trap_b), .retired(retired_b), .pc_dbg(pc_dbg_b));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory for the RV32I core: ack after ws_a wait states, log stores and data accesses.
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  int          ws_a = 0;
  int          cnt_a = 0;
  int          wr_cnt = 0;
  int          data_cnt = 0;
  logic [31:0] wr_addr = 32'd0;
  logic [31:0] wr_data = 32'd0;

  always @(negedge clk) begin
    if (rst || !mem_req) begin
      cnt_a   = 0;
      mem_ack = 1'b0;
      if (rst) begin
        wr_cnt   = 0;
        data_cnt = 0;
      end
    end else begin
      if (mem_ack) cnt_a = 0;
      if (cnt_a >= ws_a) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_a[mem_addr[9:2]];
        if (mem_addr[31:8] == 24'd0) data_cnt++;
        if (mem_we) begin
          wr_cnt++;
          wr_addr = mem_addr;
          wr_data = mem_wdata;
        end
      end else begin
        mem_ack = 1'b0;
        cnt_a++;
      end
    end
  end

  always @(negedge clk) begin
    mem_ack_b   = mem_req_b && !rst_b;
    mem_rdata_b = mem_b[mem_addr_b[9:2]];
  end

  // Cycle stamp and PC at each change of the retired count, and at HALT entry.
  int          ret_cyc [0:15];
  logic [31:0] ret_pc [0:15];
  int          halt_cyc = -1;
  logic [31:0] prev_ret = 32'd0;
  logic        seen_halt = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_ret  = 32'd0;
      seen_halt = 1'b0;
      halt_cyc  = -1;
      for (int i = 0; i < 16; i++) begin
        ret_cyc[i] = -1;
        ret_pc[i]  = 32'd0;
      end
    end else begin
      if (retired != prev_ret) begin
        ret_cyc[retired[3:0]] = cyc;
        ret_pc[retired[3:0]]  = pc_dbg;
        prev_ret = retired;
      end
      if (halted && !seen_halt) begin
        seen_halt = 1'b1;
        halt_cyc  = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_halt(input string tag, input bit on_b, input int budget);
    int n = 0;
    while (!(on_b ? halted_b : halted) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(on_b ? halted_b : halted), 32'd1);
  endtask

  task automatic clear_a();
    for (int i = 0; i < 256; i++) mem_a[i] = 32'd0;
  endtask

  task automatic restart_a(input int ws);
    @(negedge clk);
    rst  = 1'b1;
    ws_a = ws;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ff;
    int n;
    rst   = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 256; i++) mem_b[i] = 32'd0;

    // ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SW x3,0(x0); ECALL
    clear_a();
    mem_a[64] = 32'h0050_0093;
    mem_a[65] = 32'hFFD0_0113;
    mem_a[66] = 32'h0020_81B3;
    mem_a[67] = 32'h0030_2023;
    mem_a[68] = 32'h0000_0073;
    repeat (3) begin
      @(negedge clk);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_retired", retired, 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
    end
    check("rst_pc", pc_dbg, 32'h100);
    check("rst_addr", mem_addr, 32'h100);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    ff = cyc;
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", mem_addr, 32'h100);
    check("first_we", 32'(mem_we), 32'd0);
    wait_halt("p1_halt", 1'b0, 200);
    @(negedge clk);
    check("p1_retired", retired, 32'd4);
    check("p1_trap", 32'(trap), 32'd0);
    check("p1_sw_count", 32'(wr_cnt), 32'd1);
    check("p1_sw_addr", wr_addr, 32'h0);
    check("p1_sw_data", wr_data, 32'h2);
    check("p1_cpi_addi", 32'(ret_cyc[1] - ff), 32'd4);
    check("p1_cpi_addi2", 32'(ret_cyc[2] - ret_cyc[1]), 32'd4);
    check("p1_cpi_add", 32'(ret_cyc[3] - ret_cyc[2]), 32'd4);
    check("p1_cpi_sw", 32'(ret_cyc[4] - ret_cyc[3]), 32'd4);
    check("p1_ecall_cycles", 32'(halt_cyc - ret_cyc[4]), 32'd2);
    repeat (5) @(negedge clk);
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_no_req", 32'(mem_req), 32'd0);
    check("halt_retired", retired, 32'd4);
    check("halt_pc", pc_dbg, 32'h110);

    // LW x5,0x40(x0); SW x5,0x44(x0); ECALL -- three wait states on every transfer
    clear_a();
    mem_a[64] = 32'h0400_2283;
    mem_a[65] = 32'h0450_2223;
    mem_a[66] = 32'h0000_0073;
    mem_a[16] = 32'hCAFE_1234;
    restart_a(3);
    @(negedge clk);
    ff = cyc;
    repeat (3) begin
      check("fetch_wait_req", 32'(mem_req), 32'd1);
      check("fetch_wait_addr", mem_addr, 32'h100);
      @(negedge clk);
    end
    n = 0;
    while (!(mem_req && mem_addr == 32'h40) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) begin
      check("lw_wait_req", 32'(mem_req), 32'd1);
      check("lw_wait_addr", mem_addr, 32'h40);
      check("lw_wait_we", 32'(mem_we), 32'd0);
      @(negedge clk);
    end
    wait_halt("p2_halt", 1'b0, 300);
    @(negedge clk);
    check("p2_lw_cycles", 32'(ret_cyc[1] - ff), 32'd11);
    check("p2_retired", retired, 32'd2);
    check("p2_trap", 32'(trap), 32'd0);
    check("p2_sw_addr", wr_addr, 32'h44);
    check("p2_lw_value", wr_data, 32'hCAFE_1234);

    // ADDI x2,x0,3; loop: ADDI x1,x1,1; BNE x1,x2,loop; BEQ x1,x2,+8; (illegal); BEQ x1,x0,+8; ECALL
    clear_a();
    mem_a[64] = 32'h0030_0113;
    mem_a[65] = 32'h0010_8093;
    mem_a[66] = 32'hFE20_9EE3;
    mem_a[67] = 32'h0020_8463;
    mem_a[68] = 32'hFFFF_FFFF;
    mem_a[69] = 32'h0000_8463;
    mem_a[70] = 32'h0000_0073;
    restart_a(0);
    wait_halt("p3_halt", 1'b0, 300);
    @(negedge clk);
    check("bne_taken_pc1", ret_pc[3], 32'h104);
    check("bne_taken_pc2", ret_pc[5], 32'h104);
    check("bne_fall_pc", ret_pc[7], 32'h10C);
    check("beq_taken_pc", ret_pc[8], 32'h114);
    check("beq_fall_pc", ret_pc[9], 32'h118);
    check("branch_cpi", 32'(ret_cyc[3] - ret_cyc[2]), 32'd3);
    check("p3_retired", retired, 32'd9);
    check("p3_trap", 32'(trap), 32'd0);

    // LW x5,2(x0): misaligned, must halt before any data request
    clear_a();
    mem_a[64] = 32'h0020_2283;
    restart_a(0);
    @(negedge clk);
    ff = cyc;
    wait_halt("mis_halt", 1'b0, 50);
    @(negedge clk);
    check("mis_trap", 32'(trap), 32'd1);
    check("mis_retired", retired, 32'd0);
    check("mis_no_data_req", 32'(data_cnt), 32'd0);
    check("mis_halt_cycles", 32'(halt_cyc - ff), 32'd3);
    check("mis_req_low", 32'(mem_req), 32'd0);

    // RV32E: ADDI x15,x0,7 is legal, ADD x17,x1,x2 must trap
    mem_b[0] = 32'h0070_0793;
    mem_b[1] = 32'h0020_88B3;
    @(negedge clk);
    rst_b = 1'b0;
    wait_halt("e_halt", 1'b1, 100);
    check("e_trap", 32'(trap_b), 32'd1);
    check("e_retired", retired_b, 32'd1);
    check("e_pc", pc_dbg_b, 32'h4);

    // Reset while a fetch is waiting for its ack
    clear_a();
    mem_a[64] = 32'h0050_0093;
    mem_a[65] = 32'h0000_0073;
    restart_a(10);
    @(negedge clk);
    @(negedge clk);
    check("mid_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1 check("mid_req_async", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("mid_req_held", 32'(mem_req), 32'd0);
    ws_a = 0;
    rst  = 1'b0;
    @(negedge clk);
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_addr", mem_addr, 32'h100);
    wait_halt("restart_halt", 1'b0, 100);
    check("restart_retired", retired, 32'd1);
    check("restart_trap", 32'(trap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
